mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_control.sv | 161 ++++++++++++++++
 tb/tb_mc_control.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU op codes
// and the small mux-select constants the datapath expects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;

  // ALU B-input select: register, constant 4, sign-extended imm, shifted imm
  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM with retired-instruction counter.
// Define MC_CONTROL_JUMP_EN to decode opcode 000010 as a jump; otherwise it is illegal.
module mc_control
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic [15:0] instr_count,
  output logic [3:0]  state
);

  state_t      state_q, state_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state; retire marks the hop back to FETCH that completes an instruction
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:          state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
`ifdef MC_CONTROL_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MC_CONTROL_JUMP_EN
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`endif
      default:  state_d = S_IDLE;
    endcase
    instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;
  end

  // Control decode: pure function of state except ir_write/pc_we, which follow inputs
  always_comb begin
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REG;
    aluop      = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: alu_src_b = ALUB_SHIMM;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_source = PCSRC_BRANCH;
        pc_we     = zero;
      end
`ifdef MC_CONTROL_JUMP_EN
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_we     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign instr_count = instr_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a behavioural model checked every cycle,
// plus directed literal checks for each instruction class, reset and counter wrap.
module tb_mc_control;

`ifdef MC_CONTROL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_we, iord, mem_read, mem_write, ir_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, aluop, pc_source;
  logic [15:0] instr_count;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b1;
  bit preload = 1'b0;
  logic [15:0] preload_val = 16'd0;

  int          m_state = 0;
  logic [15:0] m_count = 16'd0;

  mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .pc_source(pc_source), .illegal(illegal),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction-flow rules: which step follows which, given opcode and memory handshake
  function automatic int model_next(int s, logic [5:0] op, logic rdy);
    case (s)
      0: return 1;
      1: return rdy ? 2 : 1;
      2: begin
        if (op == 6'b000000) return 7;
        if (op == 6'b100011 || op == 6'b101011) return 3;
        if (op == 6'b000100) return 9;
        if (op == 6'b000010 && JUMP_EN) return 10;
        return 1;
      end
      3: return (op == 6'b100011) ? 4 : 6;
      4: return rdy ? 5 : 4;
      6: return rdy ? 1 : 6;
      7: return 8;
      5, 8, 9: return 1;
      10: return JUMP_EN ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic outs_t model_out(int s, logic [5:0] op, logic rdy, logic z);
    outs_t o;
    o = '0;
    case (s)
      1: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_we = rdy; end
      2: begin
        o.alu_src_b = 2'b11;
        o.illegal = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                      op == 6'b000100 || (op == 6'b000010 && JUMP_EN));
      end
      3: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4: begin o.mem_read = 1; o.iord = 1; end
      5: begin o.reg_write = 1; o.mem_to_reg = 1; end
      6: begin o.mem_write = 1; o.iord = 1; end
      7: begin o.alu_src_a = 1; o.aluop = 2'b01; end
      8: begin o.reg_write = 1; o.reg_dst = 1; end
      9: begin o.alu_src_a = 1; o.aluop = 2'b10; o.pc_source = 2'b01; o.pc_we = z; end
      10: if (JUMP_EN) begin o.pc_source = 2'b10; o.pc_we = 1; end
      default: ;
    endcase
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_count <= 16'd0;
    end else begin
      m_state <= model_next(m_state, opcode, mem_ready);
      if (preload)
        m_count <= preload_val;
      else if (model_next(m_state, opcode, mem_ready) == 1 &&
               (m_state == 5 || m_state == 8 || m_state == 9 || m_state == 10 || m_state == 6))
        m_count <= m_count + 16'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  outs_t act_o;
  assign act_o = '{pc_we, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, aluop, pc_source, illegal};

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_outputs", 32'(act_o), 32'(model_out(m_state, opcode, mem_ready, zero)));
      check("cyc_state", 32'(state), 32'(m_state));
      check("cyc_count", 32'(instr_count), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_rtype();
    opcode = 6'b000000; mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    rst = 1'b0;

    // R-type: IDLE -> FETCH -> DECODE -> EXEC -> ALUWB -> FETCH
    opcode = 6'b000000; mem_ready = 1'b1;
    tick(); #1;
    check("r_fetch", 32'(state), 32'd1);
    check("r_fetch_irw", 32'(ir_write), 32'd1);
    tick(); #1; check("r_decode", 32'(state), 32'd2);
    mem_ready = 1'b0;
    tick(); #1; check("r_exec", 32'(state), 32'd7);
    check("r_exec_aluop", 32'(aluop), 32'd1);
    tick(); #1; check("r_aluwb_regdst", 32'(reg_dst), 32'd1);
    tick(); #1;
    check("r_count", 32'(instr_count), 32'd1);
    check("r_fetch_stall_irw", 32'(ir_write), 32'd0);
    tick(); #1; check("r_fetch_stall", 32'(state), 32'd1);

    // lw with three wait cycles in MEMRD
    opcode = 6'b100011; mem_ready = 1'b1;
    tick(); tick(); #1; check("lw_memadr", 32'(state), 32'd3);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      #1;
      check("lw_memrd_hold", 32'(state), 32'd4);
      check("lw_memrd_ctl", 32'({mem_read, iord}), 32'b11);
    end
    tick(); #1; check("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
    tick(); #1; check("lw_count", 32'(instr_count), 32'd2);

    // sw, reset while waiting in MEMWR
    opcode = 6'b101011;
    tick(); tick(); mem_ready = 1'b0;
    tick(); #1; check("sw_memwr", 32'(state), 32'd6);
    tick(); #1;
    rst = 1'b1; #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_memwrite", 32'(mem_write), 32'd0);
    check("async_rst_count", 32'(instr_count), 32'd0);
    tick(); rst = 1'b0; mem_ready = 1'b1;
    tick(); #1; check("post_rst_fetch", 32'(state), 32'd1);

    // beq taken and not taken
    opcode = 6'b000100;
    tick(); tick(); zero = 1'b1; #1;
    check("beq_taken", 32'({pc_we, pc_source, aluop}), 32'b1_01_10);
    tick(); #1; check("beq_count1", 32'(instr_count), 32'd1);
    tick(); tick(); zero = 1'b0; #1;
    check("beq_not_taken_pcwe", 32'(pc_we), 32'd0);
    tick(); #1; check("beq_count2", 32'(instr_count), 32'd2);

    // illegal opcode
    opcode = 6'b111111;
    tick(); #1;
    check("ill_decode", 32'(state), 32'd2);
    check("ill_pulse", 32'(illegal), 32'd1);
    tick(); #1;
    check("ill_clear", 32'(illegal), 32'd0);
    check("ill_count", 32'(instr_count), 32'd2);

    // jump: legal only when the feature is built in
    opcode = 6'b000010;
    tick(); #1;
    check("j_illegal", 32'(illegal), JUMP_EN ? 32'd0 : 32'd1);
    tick(); #1;
    check("j_state", 32'(state), JUMP_EN ? 32'd10 : 32'd1);
    check("j_pc", 32'({pc_we, pc_source}), JUMP_EN ? 32'b1_10 : 32'b1_00);
    if (JUMP_EN) tick();
    #1; check("j_count", 32'(instr_count), JUMP_EN ? 32'd3 : 32'd2);

    // counter wrap: preload near the top, then retire two R-types
    opcode = 6'b000000; mem_ready = 1'b1;
    tick();
    check_en = 1'b0;
    preload_val = 16'hFFFE; preload = 1'b1;
    force dut.instr_count_q = 16'hFFFE;
    tick();
    preload = 1'b0;
    release dut.instr_count_q;
    check_en = 1'b1;
    tick(); tick(); #1;
    check("wrap_ffff", 32'(instr_count), 32'hFFFF);
    run_rtype(); #1;
    check("wrap_zero", 32'(instr_count), 32'h0000);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
